// File: rtl/tri_setup_pkg.sv
// tri_setup_pkg: screen limits, datapath widths and FSM state type shared by tri_setup and recip_div
package tri_setup_pkg;
  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int INV_AREA_FRAC = 24;
  localparam int X_W = 9;
  localparam int Y_W = 8;
  localparam int Z_W = 16;
  localparam int A_W = 9;
  localparam int B_W = 9;
  localparam int C_W = 18;
  localparam int AREA_W = 20;
  localparam int DIV_W = 18;
  localparam int Q_W = INV_AREA_FRAC + 1;
  typedef enum logic [2:0] {IDLE, EDGES, AREA, CHECK, DIV, ISSUE, WAIT_DONE} state_t;
endpackage

// File: rtl/tri_setup_div.sv
// recip_div: restoring divider producing floor(2^24 / divisor_i), one quotient bit per cycle
//   start_i   : load and begin (divisor_i must stay stable while busy_o)
//   busy_o    : iteration in progress
//   done_o    : high during the last iteration; quot_o is final on the following cycle
//   quot_o    : 25-bit quotient
module recip_div
  import tri_setup_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Q_W-1:0]   quot_o
);
  logic [DIV_W-1:0] rem_q;
  logic [DIV_W:0]   trial;
  logic [4:0]       cnt_q;
  logic             fit;
  always_comb begin
    // the dividend 2^24 has only its top bit set, so that is the only 1 ever shifted in
    trial = {rem_q, cnt_q == 5'd0};
    fit = trial >= {1'b0, divisor_i};
    done_o = busy_o && cnt_q == 5'(Q_W - 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_o <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quot_o <= '0;
    end else if (start_i) begin
      busy_o <= 1'b1;
      cnt_q <= '0;
      rem_q <= '0;
      quot_o <= '0;
    end else if (busy_o) begin
      rem_q <= fit ? DIV_W'(trial - {1'b0, divisor_i}) : trial[DIV_W-1:0];
      quot_o <= {quot_o[Q_W-2:0], fit};
      cnt_q <= cnt_q + 5'd1;
      busy_o <= !done_o;
    end
  end
endmodule

// File: rtl/tri_setup.sv
// tri_setup: triangle setup -- edge equations, clipped bbox, 1/area, then hand-off to the rasterizer
//   tri_valid/tri_ready          : triangle accept handshake (ready only in IDLE)
//   vx*/vy*/vz*/tri_color        : vertex x/y/depth and colour
//   a*/b*/c*, bb*, z*, color     : registered setup results, stable from start until done
//   inv_area                     : floor(2^24 / |area2|)
//   rasterizer_start/_done       : launch pulse and completion pulse
//   tri_culled                   : one-cycle pulse per rejected triangle
// Build option TRI_SETUP_BACKFACE_CULL_EN: cull negative-area triangles instead of flipping them.
module tri_setup
  import tri_setup_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                tri_valid,
  output logic                tri_ready,
  input  logic [X_W-1:0]      vx1, vx2, vx3,
  input  logic [Y_W-1:0]      vy1, vy2, vy3,
  input  logic [Z_W-1:0]      vz1, vz2, vz3,
  input  logic [7:0]          tri_color,
  output logic signed [A_W-1:0] a1, a2, a3,
  output logic signed [B_W-1:0] b1, b2, b3,
  output logic signed [C_W-1:0] c1, c2, c3,
  output logic [X_W-1:0]      bbxi, bbxf,
  output logic [Y_W-1:0]      bbyi, bbyf,
  output logic [Z_W-1:0]      z1, z2, z3,
  output logic [7:0]          color,
  output logic [31:0]         inv_area,
  output logic                rasterizer_start,
  input  logic                rasterizer_done,
  output logic                tri_culled
);
`ifdef TRI_SETUP_BACKFACE_CULL_EN
  localparam bit BF = 1'b1;
`else
  localparam bit BF = 1'b0;
`endif
  typedef logic signed [A_W-1:0]  a_t;
  typedef logic signed [B_W:0]    b_t;
  typedef logic signed [C_W:0]    c_t;
  typedef logic signed [AREA_W:0] area_t;
  state_t state_q, state_d;
  logic [X_W-1:0] x_q [3];
  logic [Y_W-1:0] y_q [3];
  logic [Z_W-1:0] z_q [3];
  logic [7:0] color_q;
  // b and c carry one guard bit so out-of-range values can be detected before truncation
  a_t a_q [3];
  b_t b_q [3];
  c_t c_q [3];
  logic signed [AREA_W-1:0] area_q;
  logic [X_W-1:0] bxi_q, bxf_q, xmin, xmax;
  logic [Y_W-1:0] byi_q, byf_q, ymin, ymax;
  area_t area_w;
  logic neg, b_bad, c_bad, cull, div_start, div_busy, div_done;
  logic [Q_W-1:0] quot;
  always_comb begin
    area_w = area_t'(a_q[0]) * area_t'(x_q[0]) + area_t'(b_q[0]) * area_t'(y_q[0]) + area_t'(c_q[0]);
    neg = !BF && area_w[AREA_W];
    xmin = x_q[0];
    xmax = x_q[0];
    ymin = y_q[0];
    ymax = y_q[0];
    b_bad = 1'b0;
    c_bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xmin = x_q[i] < xmin ? x_q[i] : xmin;
      xmax = x_q[i] > xmax ? x_q[i] : xmax;
      ymin = y_q[i] < ymin ? y_q[i] : ymin;
      ymax = y_q[i] > ymax ? y_q[i] : ymax;
      b_bad = b_bad | (b_q[i][B_W] != b_q[i][B_W-1]);
      c_bad = c_bad | (c_q[i][C_W] != c_q[i][C_W-1]);
    end
    cull = area_q == '0 || bxi_q > bxf_q || byi_q > byf_q || b_bad || c_bad || (BF && area_q[AREA_W-1]);
  end
  always_comb begin
    state_d = state_q;
    tri_ready = state_q == IDLE;
    rasterizer_start = state_q == ISSUE;
    tri_culled = state_q == CHECK && cull;
    div_start = state_q == CHECK && !cull;
    case (state_q)
      IDLE:      state_d = tri_valid ? EDGES : IDLE;
      EDGES:     state_d = AREA;
      AREA:      state_d = CHECK;
      CHECK:     state_d = cull ? IDLE : DIV;
      DIV:       state_d = div_done ? ISSUE : (div_busy ? DIV : IDLE);
      ISSUE:     state_d = WAIT_DONE;
      WAIT_DONE: state_d = rasterizer_done ? IDLE : WAIT_DONE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        z_q[i] <= '0;
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
      color_q <= '0;
      area_q <= '0;
      bxi_q <= '0;
      bxf_q <= '0;
      byi_q <= '0;
      byf_q <= '0;
    end else begin
      if (tri_valid && tri_ready) begin
        x_q <= '{vx1, vx2, vx3};
        y_q <= '{vy1, vy2, vy3};
        z_q <= '{vz1, vz2, vz3};
        color_q <= tri_color;
      end
      // edge i is opposite vertex i, built from vertices i+1 and i+2
      if (state_q == EDGES)
        for (int i = 0; i < 3; i++) begin
          a_q[i] <= a_t'(y_q[(i+1)%3]) - a_t'(y_q[(i+2)%3]);
          b_q[i] <= b_t'(x_q[(i+2)%3]) - b_t'(x_q[(i+1)%3]);
          c_q[i] <= c_t'(x_q[(i+1)%3]) * c_t'(y_q[(i+2)%3]) - c_t'(x_q[(i+2)%3]) * c_t'(y_q[(i+1)%3]);
        end
      if (state_q == AREA) begin
        area_q <= neg ? -area_w[AREA_W-1:0] : area_w[AREA_W-1:0];
        for (int i = 0; i < 3; i++) begin
          a_q[i] <= neg ? -a_q[i] : a_q[i];
          b_q[i] <= neg ? -b_q[i] : b_q[i];
          c_q[i] <= neg ? -c_q[i] : c_q[i];
        end
        bxi_q <= xmin;
        bxf_q <= xmax > X_W'(SCREEN_W - 1) ? X_W'(SCREEN_W - 1) : xmax;
        byi_q <= ymin;
        byf_q <= ymax > Y_W'(SCREEN_H - 1) ? Y_W'(SCREEN_H - 1) : ymax;
      end
    end
  end
  recip_div u_div (
    .clk       (clk),
    .rst       (rst),
    .start_i   (div_start),
    .divisor_i (area_q[DIV_W-1:0]),
    .busy_o    (div_busy),
    .done_o    (div_done),
    .quot_o    (quot)
  );
  assign {a1, a2, a3} = {a_q[0], a_q[1], a_q[2]};
  assign {b1, b2, b3} = {b_q[0][B_W-1:0], b_q[1][B_W-1:0], b_q[2][B_W-1:0]};
  assign {c1, c2, c3} = {c_q[0][C_W-1:0], c_q[1][C_W-1:0], c_q[2][C_W-1:0]};
  assign {z1, z2, z3} = {z_q[0], z_q[1], z_q[2]};
  assign {bbxi, bbxf, bbyi, bbyf} = {bxi_q, bxf_q, byi_q, byf_q};
  assign color = color_q;
  assign inv_area = 32'(quot);
endmodule

// File: doc/tri_setup.md
TRI_SETUP -- requirements
Module: tri_setup

Interface
REQ-001 clk  input  1  system clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 tri_valid  input  1  upstream triangle offered.
REQ-004 tri_ready  output  1  block can accept a triangle; high only in IDLE.
REQ-005 vx1, vx2, vx3  input  9 each  unsigned screen x of vertices 1..3.
REQ-006 vy1, vy2, vy3  input  8 each  unsigned screen y of vertices 1..3.
REQ-007 vz1, vz2, vz3  input  16 each  unsigned screen-space depth of vertices 1..3.
REQ-008 tri_color  input  8  triangle colour.
REQ-009 a1..a3, b1..b3  output  9 signed each  edge x/y coefficients.
REQ-010 c1..c3  output  18 signed each  edge constant terms.
REQ-011 bbxi, bbxf  output  9 each; bbyi, bbyf  output  8 each  clipped bounding box, inclusive.
REQ-012 z1, z2, z3  output  16 each; color  output  8  registered vertex depths and colour.
REQ-013 inv_area  output  32  floor(2^24 / area2), unsigned.
REQ-014 rasterizer_start  output  1  one-cycle launch pulse.
REQ-015 rasterizer_done  input  1  one-cycle completion pulse from the downstream rasterizer.
REQ-016 tri_culled  output  1  one-cycle pulse per rejected triangle.

Function
REQ-017 Accept on tri_valid && tri_ready (cycle T); register all vertex, depth and colour inputs.
REQ-018 Edge i is opposite vertex i: a1=y2-y3, b1=x3-x2, c1=x2*y3-x3*y2; a2, b2, c2 and a3, b3, c3 follow the same rule using (v3,v1) and (v1,v2); products are registered in state EDGES (T+1).
REQ-019 AREA (T+2): area2 = a1*x1 + b1*y1 + c1, held at 20 bits signed; bbox = min/max of vertices, clipped to x 0..319, y 0..239.
REQ-020 CHECK (T+3): the triangle is culled if any of the following holds: area2 == 0; clipped bbox empty (min>max); any b outside -256..255; any c outside the 18-bit signed range.
REQ-021 area2 < 0: handling is set by the configuration in REQ-029.
REQ-022 On a cull, tri_culled pulses during CHECK, the state returns to IDLE, and tri_ready is high at T+4; rasterizer_start does not pulse.
REQ-023 DIV (T+4..T+28): restoring divide of 2^24 by |area2|, one quotient bit per cycle, 25 iterations, quotient bits 24..0; upper bits of inv_area are zero.
REQ-024 ISSUE (T+29): rasterizer_start=1 for exactly one cycle, then WAIT_DONE.
REQ-025 All outputs to the rasterizer are stable from ISSUE until rasterizer_done is sampled high.
REQ-026 WAIT_DONE -> IDLE on rasterizer_done; tri_ready is high the following cycle.
REQ-027 rasterizer_done in any state other than WAIT_DONE is ignored.
REQ-028 State sequence: IDLE -> EDGES -> AREA -> CHECK -> {IDLE | DIV -> ISSUE -> WAIT_DONE -> IDLE}.

Configuration
REQ-029 TRI_SETUP_BACKFACE_CULL_EN: when defined, area2 < 0 culls the triangle per REQ-022. When undefined, area2 < 0 negates all a, b, c and area2 before the range checks, and the triangle then proceeds normally.

Reset
REQ-030 On rst the state goes to IDLE, with tri_ready=1, rasterizer_start=0 and tri_culled=0.
REQ-031 On rst all coefficient, bbox, z, color and inv_area outputs are 0, the divider is cleared, and any in-flight triangle is discarded.
REQ-032 rst wins over every simultaneous event, including tri_valid and rasterizer_done.

Structure
REQ-033 Package tri_setup_pkg holds SCREEN_W=320, SCREEN_H=240, INV_AREA_FRAC=24, the coefficient width parameters and the state enum typedef.
REQ-034 Sub-module recip_div implements the 25-cycle sequential divider with start/busy/done and an 18-bit unsigned divisor.

Verification
REQ-035 v1=(0,0), v2=(10,0), v3=(0,10) -> a1=-10, b1=-10, c1=100, area2=100, inv_area=0x00028F5C, bbox 0..10/0..10, rasterizer_start at T+29.
REQ-036 Same triangle with v2/v3 swapped -> with macro: tri_culled at T+3 and no start; without macro: a1=-10, b1=-10, c1=100, inv_area=0x00028F5C.
REQ-037 Collinear (0,0),(5,5),(10,10) -> tri_culled, tri_ready high at T+4; area2=1 triangle (0,0),(1,0),(0,1) -> inv_area=0x01000000.
REQ-038 Vertices with x=400..450 -> bbox empty -> culled; vertex x2=300, x3=0 -> b1=-300 out of range -> culled.
REQ-039 Hold tri_valid high while the rasterizer is busy -> no second accept before rasterizer_done; a stray rasterizer_done during DIV is ignored.
REQ-040 Assert rst at DIV cycle 10 -> next cycle IDLE, all outputs 0, no rasterizer_start pulse.
